// File: rtl/result_display.sv
// Four-digit hex display driver for a 16-bit result bus: captures changes,
// scans a common-anode 7-segment display and flashes the decimal points after each capture.
module result_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int FLASH_CYCLES = 25000000,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] result_in,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [15:0] value
);

  localparam int DIV_W   = $clog2(REFRESH_DIV + 1);
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         digit_sel;
  logic [FLASH_W-1:0] flash_cnt;
  logic               tick;
  logic               capture;

  logic [3:0] nibble_p0;
  logic       blank_p0;
  logic [3:0] an_p0;
  logic [6:0] seg_p0;
  logic       dp_p0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  function automatic logic [FLASH_W-1:0] sat_dec(input logic [FLASH_W-1:0] x);
    sat_dec = (x == '0) ? '0 : x - FLASH_W'(1);
  endfunction

  assign tick    = (div_cnt == DIV_LAST);
  assign capture = !hold && (result_in != value);

  // Stage p0: decode the digit about to be enabled from the current value.
  always_comb begin
    nibble_p0 = value[3:0];
    blank_p0  = 1'b0;
    case (digit_sel)
      2'd1: begin
        nibble_p0 = value[7:4];
        blank_p0  = BLANK_LZ && (value[15:4] == 12'd0);
      end
      2'd2: begin
        nibble_p0 = value[11:8];
        blank_p0  = BLANK_LZ && (value[15:8] == 8'd0);
      end
      2'd3: begin
        nibble_p0 = value[15:12];
        blank_p0  = BLANK_LZ && (value[15:12] == 4'd0);
      end
      default: begin
        nibble_p0 = value[3:0];
        blank_p0  = 1'b0;
      end
    endcase
    an_p0  = 4'b1111;
    seg_p0 = 7'b1111111;
    dp_p0  = 1'b1;
    if (!blank_p0) begin
      an_p0  = ~(4'b0001 << digit_sel);
      seg_p0 = hex_to_seg(nibble_p0);
      dp_p0  = (flash_cnt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value     <= 16'd0;
      flash_cnt <= '0;
    end else if (capture) begin
      value     <= result_in;
      flash_cnt <= FLASH_LOAD;
    end else begin
      flash_cnt <= sat_dec(flash_cnt);
    end
  end

  // Stage p1: registered display outputs, updated only on scan ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel <= 2'd0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else if (tick) begin
      digit_sel <= digit_sel + 2'd1;
      an        <= an_p0;
      seg       <= seg_p0;
      dp        <= dp_p0;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: two instances (leading-zero blanking off/on) checked every
// cycle against a timing model, plus hand-computed literal expectations.
module tb_result_display;

  localparam int REFRESH_DIV  = 4;
  localparam int FLASH_CYCLES = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] result_in;
  logic        hold;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic        dp0, dp1;
  logic [15:0] value0, value1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_display #(.REFRESH_DIV(REFRESH_DIV), .FLASH_CYCLES(FLASH_CYCLES), .BLANK_LZ(1'b0)) u_full (
    .clk(clk), .rst(rst), .result_in(result_in), .hold(hold),
    .seg(seg0), .an(an0), .dp(dp0), .value(value0)
  );

  result_display #(.REFRESH_DIV(REFRESH_DIV), .FLASH_CYCLES(FLASH_CYCLES), .BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst(rst), .result_in(result_in), .hold(hold),
    .seg(seg1), .an(an1), .dp(dp1), .value(value1)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: outputs derived from edge count since reset and the time of the last capture.
  int          n_edge   = 0;
  int          last_cap = -1;
  int          d_m;
  logic        lit_m;
  logic [15:0] m_value  = 16'd0;
  logic [3:0]  e_an  [2];
  logic [6:0]  e_seg [2];
  logic        e_dp  [2];

  task automatic model_reset();
    n_edge   = 0;
    last_cap = -1;
    m_value  = 16'd0;
    for (int b = 0; b < 2; b++) begin
      e_an[b]  = 4'b1111;
      e_seg[b] = 7'b1111111;
      e_dp[b]  = 1'b1;
    end
  endtask

  task automatic model_edge();
    if (n_edge % REFRESH_DIV == REFRESH_DIV - 1) begin
      d_m   = (n_edge / REFRESH_DIV) % 4;
      lit_m = (last_cap >= 0) && (n_edge - last_cap <= FLASH_CYCLES - 1);
      for (int b = 0; b < 2; b++) begin
        if (b == 1 && d_m != 0 && (m_value >> (4 * d_m)) == 16'd0) begin
          e_an[b]  = 4'b1111;
          e_seg[b] = 7'b1111111;
          e_dp[b]  = 1'b1;
        end else begin
          e_an[b]  = ~(4'b0001 << d_m);
          e_seg[b] = seg_tab[m_value[4*d_m +: 4]];
          e_dp[b]  = ~lit_m;
        end
      end
    end
    if (!hold && result_in != m_value) begin
      m_value  = result_in;
      last_cap = n_edge;
    end
    n_edge++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("an_full",     16'(an0),  16'(e_an[0]));
      chk("seg_full",    16'(seg0), 16'(e_seg[0]));
      chk("dp_full",     16'(dp0),  16'(e_dp[0]));
      chk("value_full",  value0,    m_value);
      chk("an_blank",    16'(an1),  16'(e_an[1]));
      chk("seg_blank",   16'(seg1), 16'(e_seg[1]));
      chk("dp_blank",    16'(dp1),  16'(e_dp[1]));
      chk("value_blank", value1,    m_value);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    result_in = 16'h0000;
    hold      = 1'b0;
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;

    // 1: dark for a slot, then digit 0 shows 0, upper digits blanked
    step(3);
    chk("t1_dark_blank", 16'(an1), 16'h000F);
    chk("t1_dark_full",  16'(an0), 16'h000F);
    step(1);
    chk("t1_an", 16'(an1), 16'h000E);
    chk("t1_seg", 16'(seg1), 16'h0040);
    chk("t1_dp", 16'(dp1), 16'h0001);
    step(12);

    // 2: capture 12AF, one full scan
    result_in = 16'h12AF;
    step(1);
    chk("t2_value", value1, 16'h12AF);
    step(3);
    chk("t2_an0", 16'(an1), 16'h000E);
    chk("t2_seg0", 16'(seg1), 16'h000E);
    chk("t2_dp0", 16'(dp1), 16'h0000);
    step(4);
    chk("t2_an1", 16'(an1), 16'h000D);
    chk("t2_seg1", 16'(seg1), 16'h0008);
    chk("t2_dp1", 16'(dp1), 16'h0000);
    step(4);
    chk("t2_an2", 16'(an1), 16'h000B);
    chk("t2_seg2", 16'(seg1), 16'h0024);
    chk("t2_dp2", 16'(dp1), 16'h0001);
    step(4);
    chk("t2_an3", 16'(an1), 16'h0007);
    chk("t2_seg3", 16'(seg1), 16'h0079);
    chk("t2_dp3", 16'(dp1), 16'h0001);

    // 3: 0005 with and without leading-zero blanking
    result_in = 16'h0005;
    step(4);
    chk("t3_seg0_blank", 16'(seg1), 16'h0012);
    chk("t3_seg0_full",  16'(seg0), 16'h0012);
    step(4);
    chk("t3_an1_blank",  16'(an1),  16'h000F);
    chk("t3_seg1_blank", 16'(seg1), 16'h007F);
    chk("t3_an1_full",   16'(an0),  16'h000D);
    chk("t3_seg1_full",  16'(seg0), 16'h0040);
    step(8);

    // 4: hold freezes the value, release captures and restarts flash
    hold      = 1'b1;
    result_in = 16'h0007;
    step(8);
    chk("t4_value_held", value1, 16'h0005);
    chk("t4_dp_held", 16'(dp0), 16'h0001);
    hold = 1'b0;
    step(1);
    chk("t4_value_rel", value1, 16'h0007);
    step(3);
    chk("t4_dp_flash", 16'(dp0), 16'h0000);
    chk("t4_an", 16'(an0), 16'h000B);
    chk("t4_seg", 16'(seg0), 16'h0040);

    // 5: second change four cycles after the first reloads the flash
    result_in = 16'h0030;
    step(4);
    result_in = 16'h0031;
    step(8);
    chk("t5_dp_reload_full",  16'(dp0), 16'h0000);
    chk("t5_dp_reload_blank", 16'(dp1), 16'h0000);
    step(4);
    chk("t5_dp_expired", 16'(dp0), 16'h0001);

    // 6: asynchronous reset in the middle of a slot
    result_in = 16'h12AF;
    step(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_an",    16'(an0),  16'h000F);
    chk("t6_seg",   16'(seg0), 16'h007F);
    chk("t6_dp",    16'(dp0),  16'h0001);
    chk("t6_value", value1,    16'h0000);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    chk("t6_dark", 16'(an1), 16'h000F);
    step(1);
    chk("t6_first_an", 16'(an1), 16'h000E);
    chk("t6_first_seg", 16'(seg1), 16'h000E);
    chk("t6_first_dp", 16'(dp1), 16'h0000);
    step(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
